// File: rtl/pipe_pattern_check.sv
// Pipe-in pattern checker and pipe-out pattern generator with throttling.
// Optional first-error capture is built when PIPE_CHECK_FIRST_ERR_EN is defined.
//
// Ports:
//   clk, reset_n (async, active low), restart (sync, one cycle)
//   mode        : 0 counter, 1 LFSR, 2 walking-one, 3 checkerboard
//   in_write / in_data / in_ready    : pipe-in endpoint side
//   out_read / out_data / out_valid  : pipe-out endpoint side
//   error_count : saturating mismatch count
//   word_count  : accepted pipe-in words, wraps
//   overrun / underrun : sticky protocol violation flags
//   first_err_index / first_err_data : first mismatch capture (optional)

module pipe_throttle #(
    parameter int BLOCK_SIZE = 256,
    parameter int GAP_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic init,
    input  logic xfer,
    output logic ready
);
    typedef enum logic {RUN, GAP} state_t;

    localparam logic [31:0] BLK_LAST = 32'(BLOCK_SIZE - 1);
    localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);
    localparam bit THROTTLE = (GAP_CYCLES > 0);

    state_t      state;
    logic [31:0] blk_cnt;
    logic [31:0] gap_cnt;

    // ready is held low until the first clock after reset so that the
    // pattern state has been loaded before any transfer is allowed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RUN;
            blk_cnt <= '0;
            gap_cnt <= '0;
            ready   <= 1'b0;
        end else if (init) begin
            state   <= RUN;
            blk_cnt <= '0;
            gap_cnt <= '0;
            ready   <= 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (xfer) begin
                        if (blk_cnt == BLK_LAST) begin
                            blk_cnt <= '0;
                            if (THROTTLE) begin
                                state   <= GAP;
                                gap_cnt <= '0;
                                ready   <= 1'b0;
                            end
                        end else begin
                            blk_cnt <= blk_cnt + 32'd1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

module pipe_pattern_check #(
    parameter int          DATA_WIDTH = 16,
    parameter int          ERR_WIDTH  = 16,
    parameter int          BLOCK_SIZE = 256,
    parameter int          GAP_CYCLES = 0,
    parameter logic [31:0] SEED       = 32'h0000_0001
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  restart,
    input  logic [1:0]            mode,
    input  logic                  in_write,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  out_read,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic [ERR_WIDTH-1:0]  error_count,
    output logic [31:0]           word_count,
    output logic                  overrun,
    output logic                  underrun,
    output logic [31:0]           first_err_index,
    output logic [DATA_WIDTH-1:0] first_err_data
);
    localparam logic [DATA_WIDTH-1:0] ONE_W = DATA_WIDTH'(1);
    localparam logic [ERR_WIDTH-1:0]  ONE_E = ERR_WIDTH'(1);

    // State is 32 bits wide for every pattern because the LFSR needs the
    // full register; the other patterns only use the low DATA_WIDTH bits.
    function automatic logic [31:0] pat_init(input logic [1:0] m);
        logic [31:0] r;
        r = '0;
        unique case (m)
            2'd0: r = '0;
            2'd1: r = SEED;
            2'd2: r = 32'd1;
            2'd3: r[DATA_WIDTH-1:0] = {(DATA_WIDTH/2){2'b10}};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pat_next(input logic [1:0]  m,
                                             input logic [31:0] s);
        logic [DATA_WIDTH-1:0] v;
        logic [31:0]           r;
        v = s[DATA_WIDTH-1:0];
        r = '0;
        unique case (m)
            2'd0: r[DATA_WIDTH-1:0] = v + ONE_W;
            2'd1: r = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
            2'd2: r[DATA_WIDTH-1:0] = {v[DATA_WIDTH-2:0], v[DATA_WIDTH-1]};
            2'd3: r[DATA_WIDTH-1:0] = ~v;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic        boot;
    logic        init;
    logic [1:0]  mode_q;
    logic [31:0] gen_st;
    logic [31:0] chk_st;
    logic        in_fire;
    logic        out_fire;
    logic        mismatch;

    // boot makes the first clock after reset behave like a restart, so the
    // mode pin is sampled synchronously rather than inside the async reset.
    assign init     = boot | restart;
    assign in_fire  = in_write & in_ready;
    assign out_fire = out_read & out_valid;
    assign mismatch = in_data != chk_st[DATA_WIDTH-1:0];
    assign out_data = gen_st[DATA_WIDTH-1:0];

    pipe_throttle #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_in_thr (
        .clk     (clk),
        .reset_n (reset_n),
        .init    (init),
        .xfer    (in_fire),
        .ready   (in_ready)
    );

    pipe_throttle #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_out_thr (
        .clk     (clk),
        .reset_n (reset_n),
        .init    (init),
        .xfer    (out_fire),
        .ready   (out_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            boot        <= 1'b1;
            mode_q      <= 2'd0;
            gen_st      <= '0;
            chk_st      <= '0;
            error_count <= '0;
            word_count  <= '0;
            overrun     <= 1'b0;
            underrun    <= 1'b0;
        end else if (init) begin
            boot        <= 1'b0;
            mode_q      <= mode;
            gen_st      <= pat_init(mode);
            chk_st      <= pat_init(mode);
            error_count <= '0;
            word_count  <= '0;
            overrun     <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            if (out_fire) begin
                gen_st <= pat_next(mode_q, gen_st);
            end
            if (out_read && !out_valid) begin
                underrun <= 1'b1;
            end
            if (in_fire) begin
                chk_st     <= pat_next(mode_q, chk_st);
                word_count <= word_count + 32'd1;
                if (mismatch && (error_count != '1)) begin
                    error_count <= error_count + ONE_E;
                end
            end
            if (in_write && !in_ready) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef PIPE_CHECK_FIRST_ERR_EN
    logic err_seen;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_seen        <= 1'b0;
            first_err_index <= '0;
            first_err_data  <= '0;
        end else if (init) begin
            err_seen        <= 1'b0;
            first_err_index <= '0;
            first_err_data  <= '0;
        end else if (in_fire && mismatch && !err_seen) begin
            err_seen        <= 1'b1;
            first_err_index <= word_count;
            first_err_data  <= in_data;
        end
    end
`else
    assign first_err_index = '0;
    assign first_err_data  = '0;
`endif

endmodule

// File: doc/pipe_pattern_check.md
Name: pipe_pattern_check

Overview:
- Parametrised successor to the per-direction pipe checkers: one block holding a pattern generator for a pipe-out endpoint and a pattern checker for a pipe-in endpoint.
- Adds four selectable patterns, width parametrisation, block/gap throttling of ready/valid, overrun/underrun detection, a saturating error counter and a transferred-word counter.
- Sits between the okBTPipeIn/okBTPipeOut endpoints and wire-out registers in transfer-integrity and bandwidth test designs.

Parameters:
- DATA_WIDTH, 16, pipe word width; legal values 8, 16, 32.
- ERR_WIDTH, 16, width of error_count; saturates at all-ones.
- BLOCK_SIZE, 256, words accepted (in) or supplied (out) before a throttle gap; legal range ≥1.
- GAP_CYCLES, 0, ready/valid low cycles after each block; 0 disables throttling.
- SEED, 32'h0000_0001, LFSR initial state; must be nonzero.

Ports:
- clk  in  1  pipe clock (ti_clk).
- reset_n  in  1  asynchronous active-low reset.
- restart  in  1  synchronous restart from wire-in; same effect as reset, one cycle.
- mode  in  2  pattern select: 0 counter, 1 LFSR, 2 walking-one, 3 checkerboard.
- in_write  in  1  pipe-in write strobe.
- in_data  in  DATA_WIDTH  pipe-in data.
- in_ready  out  1  pipe-in ready.
- out_read  in  1  pipe-out read strobe.
- out_data  out  DATA_WIDTH  pipe-out data.
- out_valid  out  1  pipe-out ready/valid.
- error_count  out  ERR_WIDTH  saturating mismatch count.
- word_count  out  32  accepted pipe-in words, wraps.
- overrun  out  1  sticky: in_write while in_ready low.
- underrun  out  1  sticky: out_read while out_valid low.
- first_err_index  out  32  word_count value at first mismatch.
- first_err_data  out  DATA_WIDTH  received data at first mismatch.

Behaviour:
- Reset/restart:
  - Counters, sticky flags and first_err_* clear to 0.
  - Both pattern states load from the selected pattern's initial value; mode is latched.
  - in_ready=1, out_valid=1 and both throttle FSMs enter RUN, all on the first clk after reset_n deassertion or in the restart cycle.
  - mode changes between restarts are ignored.
- Patterns (state W, presented value = current state before advance):
  - Counter: starts 0, +1 mod 2^DATA_WIDTH.
  - LFSR: 32-bit Fibonacci, state <= {state[30:0], state[31]^state[21]^state[1]^state[0]}, value = state[DATA_WIDTH-1:0].
  - Walking-one: starts 1, rotate left by 1.
  - Checkerboard: starts 0xAA.. (DATA_WIDTH bits), alternates with bitwise inverse.
- Generator and checker each own an independent pattern state.
- Pipe-out:
  - out_data shows the current word whenever out_valid=1.
  - A cycle with out_read=1 and out_valid=1 consumes it; out_data shows the next word from the following edge.
  - out_read with out_valid=0 sets underrun and does not advance the generator.
- Pipe-in:
  - A cycle with in_write=1 and in_ready=1 accepts a word and compares in_data to expected.
  - On mismatch, error_count increments by 1 unless all-ones.
  - Expected state advances on every accepted word, match or not; word_count increments and wraps at 2^32.
  - in_write with in_ready=0 sets overrun; the word is discarded and neither state nor word_count changes.
- Throttle FSM (one per direction), states RUN and GAP:
  - RUN: count transfers; on the BLOCK_SIZE-th transfer, go to GAP if GAP_CYCLES>0 and drop ready/valid the next cycle.
  - GAP: hold low for exactly GAP_CYCLES cycles, then RUN with the count cleared.
  - GAP_CYCLES=0: FSM stays in RUN permanently.
- Simultaneous read and write in one cycle are fully independent.
- Asynchronous reset mid-block aborts all state immediately.

Optional Feature:
- PIPE_CHECK_FIRST_ERR_EN defined:
  - First mismatch after reset/restart loads first_err_index (word_count before increment) and first_err_data.
  - Both registers hold until the next reset/restart.
- Not defined: first_err_index and first_err_data are tied to 0 and no capture registers are built.

Test Plan:
- DATA_WIDTH=16, mode=1, restart, read 4 words → out_data 0x0001, 0x0003, 0x0006, 0x000D; underrun=0.
- mode=0, write 0x0000..0x03FF (1024 words) → error_count=0, word_count=1024, overrun=0.
- mode=0, write 0,1,0xBEEF,3,4 → error_count=1; with PIPE_CHECK_FIRST_ERR_EN: first_err_index=2, first_err_data=0xBEEF.
- BLOCK_SIZE=4, GAP_CYCLES=3, in_write held high → in_ready low for exactly 3 cycles after every 4th accepted word; write during gap sets overrun with word_count unchanged.
- ERR_WIDTH=4, mode=2, write 20 all-zero words → error_count saturates at 0xF.
- Assert reset_n low mid-block then release → all outputs at reset values; next read returns the pattern's first word.
